// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state encoding and slot-count derivation for demux_packer
//
// Contents:
//   state_t    : FSM encoding (FILL collects words, HOLD presents the frame)
//   slot_count : number of slots addressed by an aw-bit slot address
package demux_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int slot_count(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// rtl/addr_decoder.sv - slot address to one-hot write-enable decoder
//
// Ports:
//   address : slot address (ADDRESS_WIDTH bits)
//   accept  : a word is accepted this cycle; gates every enable
//   we      : one-hot write enable, N = 2**ADDRESS_WIDTH bits
module addr_decoder
  import demux_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 2,
  localparam int N = slot_count(ADDRESS_WIDTH)
) (
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                     accept,
  output logic [N-1:0]             we
);

  always_comb begin
    we          = '0;
    we[address] = accept;
  end

endmodule

// File: rtl/demux_packer.sv
// rtl/demux_packer.sv - packs address-tagged words into a frame handed off with valid/ready
//
// Build option: DEMUX_AUTO_ADDR_EN - when defined, an internal counter picks
// the slot (serial-to-parallel mode) and the address port is ignored.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : word offered         in_ready  : word accepted this cycle
//   data_in    : word to store        address   : destination slot
//   in_last    : closes the frame early when sampled with an accepted word
//   out_valid  : frame available      out_ready : downstream takes the frame
//   data_out   : packed frame, slot i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
//   slot_valid : bit i set when slot i was written in the current frame
module demux_packer
  import demux_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 2,
  localparam int N = slot_count(ADDRESS_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH*N-1:0] data_out,
  output logic [N-1:0]            slot_valid
);

  state_t                   state;
  state_t                   state_next;
  logic                     accept;
  logic                     handoff;
  logic                     frame_full;
  logic [ADDRESS_WIDTH-1:0] slot_sel;
  logic [N-1:0]             we;

  // in_ready is low during reset so nothing is written while rst is held
  assign in_ready  = (state == FILL) && !rst;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign handoff   = (state == HOLD) && out_ready;

`ifdef DEMUX_AUTO_ADDR_EN
  logic [ADDRESS_WIDTH-1:0] auto_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (handoff) begin
      auto_cnt <= '0;
    end else if (accept) begin
      auto_cnt <= auto_cnt + ADDRESS_WIDTH'(1);
    end
  end

  assign slot_sel   = auto_cnt;
  assign frame_full = (auto_cnt == ADDRESS_WIDTH'(N - 1));
`else
  assign slot_sel   = address;
  // include the write happening this cycle so the frame closes on its last slot
  assign frame_full = &(slot_valid | we);
`endif

  addr_decoder #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_addr_decoder (
    .address(slot_sel),
    .accept (accept),
    .we     (we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (accept && (frame_full || in_last)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      slot_valid <= '0;
    end else if (handoff) begin
      data_out   <= '0;
      slot_valid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (we[i]) begin
          data_out[DATA_WIDTH*i +: DATA_WIDTH] <= data_in;
        end
      end
      slot_valid <= slot_valid | we;
    end
  end

endmodule

// File: tb/tb_demux_packer.sv
// tb/tb_demux_packer.sv - self-checking bench for demux_packer (DATA_WIDTH=8, ADDRESS_WIDTH=2)
module tb_demux_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  data_in;
  logic [1:0]  address;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [3:0]  slot_valid;

  int n_checks = 0;
  int n_fail   = 0;

  demux_packer #(
    .DATA_WIDTH   (8),
    .ADDRESS_WIDTH(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .address   (address),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .slot_valid(slot_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a frame is an array of words plus a written-set;
  // it is held once every slot is written or a last word arrives.
  logic [7:0] m_slot [4];
  logic [3:0] m_mask;
  bit         m_hold;
  int         m_cnt;
  bit         m_on = 0;

  initial begin
    int a;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_on   = 1;
        m_hold = 0;
        m_mask = '0;
        m_cnt  = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
      end else if (!m_hold) begin
        if (in_valid) begin
`ifdef DEMUX_AUTO_ADDR_EN
          a = m_cnt;
`else
          a = int'(address);
`endif
          m_slot[a] = data_in;
          m_mask[a] = 1'b1;
          m_cnt     = (m_cnt + 1) % 4;
          if (m_mask == 4'hF || in_last) m_hold = 1;
        end
      end else if (out_ready) begin
        m_hold = 0;
        m_mask = '0;
        m_cnt  = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
      end
    end
  end

  initial begin
    logic [31:0] exp_data;
    forever begin
      @(posedge clk);
      #2;
      if (m_on) begin
        exp_data = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, (!m_hold && !rst)});
        chk("cyc_data_out", data_out, exp_data);
        chk("cyc_slot_valid", {28'd0, slot_valid}, {28'd0, m_mask});
      end
    end
  end

  // Drive one cycle of inputs; returns at the following falling edge.
  task automatic cyc(input logic v, input logic [1:0] a, input logic [7:0] d,
                     input logic l, input logic o, input logic r);
    in_valid  = v;
    address   = a;
    data_in   = d;
    in_last   = l;
    out_ready = o;
    rst       = r;
    @(negedge clk);
  endtask

  task automatic lit_frame(input string name, input logic [31:0] d, input logic [3:0] sv,
                           input logic ov);
    chk({name, "_data"}, data_out, d);
    chk({name, "_mask"}, {28'd0, slot_valid}, {28'd0, sv});
    chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, ov});
  endtask

  initial begin
    rst = 1; in_valid = 0; address = 0; data_in = 0; in_last = 0; out_ready = 0;
    @(negedge clk);
    cyc(0, 0, 8'h00, 0, 0, 1);
    cyc(1, 1, 8'h99, 0, 1, 1);
    lit_frame("reset", 32'h0, 4'h0, 1'b0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

`ifdef DEMUX_AUTO_ADDR_EN
    for (int i = 0; i < 4; i++) cyc(1, 3, 8'hA0 + 8'(i), 0, 0, 0);
    lit_frame("auto_full", 32'hA3A2A1A0, 4'hF, 1'b1);
    repeat (3) cyc(1, 3, 8'hEE, 0, 0, 0);
    lit_frame("auto_bp", 32'hA3A2A1A0, 4'hF, 1'b1);
    cyc(0, 3, 8'h00, 0, 1, 0);
    lit_frame("auto_handoff", 32'h0, 4'h0, 1'b0);
    cyc(1, 3, 8'hB0, 1, 0, 0);
    lit_frame("auto_last", 32'h000000B0, 4'h1, 1'b1);
    cyc(0, 3, 8'h00, 0, 1, 0);
    cyc(1, 3, 8'hC0, 0, 0, 0);
    cyc(1, 3, 8'hC1, 0, 0, 0);
    cyc(0, 3, 8'h00, 0, 0, 1);
    lit_frame("auto_rst", 32'h0, 4'h0, 1'b0);
    cyc(1, 2, 8'hC2, 0, 0, 0);
    cyc(0, 2, 8'h00, 0, 0, 0);
    lit_frame("auto_after_rst", 32'h000000C2, 4'h1, 1'b0);
    for (int i = 1; i < 4; i++) cyc(1, 0, 8'hC2 + 8'(i), 0, 0, 0);
    lit_frame("auto_full2", 32'hC5C4C3C2, 4'hF, 1'b1);
    cyc(0, 0, 8'h00, 0, 1, 0);
`else
    cyc(1, 0, 8'h11, 0, 0, 0);
    cyc(1, 1, 8'h22, 0, 0, 0);
    cyc(1, 2, 8'h33, 0, 0, 0);
    cyc(1, 3, 8'h44, 0, 0, 0);
    lit_frame("full", 32'h44332211, 4'hF, 1'b1);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) cyc(1, 0, 8'hEE, 0, 0, 0);
    lit_frame("backpressure", 32'h44332211, 4'hF, 1'b1);
    cyc(0, 0, 8'h00, 0, 1, 0);
    lit_frame("handoff", 32'h0, 4'h0, 1'b0);
    chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);

    cyc(1, 2, 8'hAB, 1, 0, 0);
    lit_frame("early_close", 32'h00AB0000, 4'b0100, 1'b1);
    cyc(0, 0, 8'h00, 0, 1, 0);

    // out_ready during FILL must not disturb the frame
    cyc(1, 1, 8'h05, 0, 1, 0);
    cyc(1, 1, 8'h07, 0, 1, 0);
    lit_frame("overwrite_mid", 32'h00000700, 4'b0010, 1'b0);
    cyc(1, 0, 8'h01, 0, 0, 0);
    cyc(1, 2, 8'h03, 0, 0, 0);
    cyc(1, 3, 8'h04, 0, 0, 0);
    lit_frame("overwrite", 32'h04030701, 4'hF, 1'b1);
    cyc(0, 0, 8'h00, 0, 1, 0);

    cyc(1, 0, 8'hC0, 0, 0, 0);
    cyc(1, 1, 8'hC1, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    lit_frame("mid_rst", 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 2'(i), 8'hD0 + 8'(i), 0, 0, 0);
    lit_frame("after_rst", 32'hD3D2D1D0, 4'hF, 1'b1);
    // handoff followed immediately by the next frame's first word
    cyc(1, 3, 8'h5A, 0, 1, 0);
    cyc(1, 3, 8'h5B, 1, 0, 0);
    lit_frame("b2b", 32'h5B000000, 4'b1000, 1'b1);
    cyc(0, 0, 8'h00, 0, 0, 1);
    lit_frame("hold_rst", 32'h0, 4'h0, 1'b0);
`endif
    cyc(0, 0, 8'h00, 0, 0, 0);
    cyc(0, 0, 8'h00, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
